// File: rtl/calc_result_display_if.sv
// Conversion handshake between the calculator datapath and the result display.
// The master side (datapath) presents Value/Flag and pulses Load.
// The slave side (display decoder) reports Busy/Ready and the latched
// Digits/ErrShown.
interface calc_result_display_if;
  logic [16:0] Value;
  logic        Flag;
  logic        Load;
  logic        Busy;
  logic        Ready;
  logic [23:0] Digits;
  logic        ErrShown;

  modport master (
    output Value, Flag, Load,
    input  Busy, Ready, Digits, ErrShown
  );

  modport slave (
    input  Value, Flag, Load,
    output Busy, Ready, Digits, ErrShown
  );
endinterface

// File: rtl/calc_result_display.sv
// Result display decoder.
//
// Converts a 17-bit binary result into six BCD digits. The conversion uses a
// sequential double-dabble that processes one bit per cycle. The digits are
// then shown on a time-multiplexed six-digit common-anode seven-segment
// display. While ErrShown is set, the display reads "Err".
//
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above
// digit0. It does not apply while the Err display is shown.
//
// state | meaning
// IDLE  | Ready, waiting for Load
// CONV  | 17 add-3/shift steps, one per cycle
// LATCH | copy scratch and pending flag to the displayed registers
module calc_result_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  calc_result_display_if.slave  bus,
  output logic [5:0]            An,
  output logic [6:0]            Seg,
  output logic                  Dp
);

  localparam int SCAN_CW = $clog2(SCAN_DIV);
  localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t              state_q;
  logic [16:0]         shreg_q;
  logic [23:0]         scratch_q;
  logic [4:0]          bitcnt_q;
  logic                pend_flag_q;
  logic                busy_q;
  logic                ready_q;
  logic [23:0]         digits_q;
  logic                err_q;
  logic [SCAN_CW-1:0]  scan_cnt_q;
  logic [2:0]          scan_idx_q;

  logic [23:0]         scratch_d;
  logic [3:0]          nib;
  logic                lead_blank;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble add-3 step applied to every scratch nibble before the shift.
  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < 6; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5)
        scratch_d[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion FSM with registered handshake outputs and latched result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      scratch_q   <= '0;
      bitcnt_q    <= '0;
      pend_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      digits_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Load) begin
            shreg_q     <= bus.Value;
            pend_flag_q <= bus.Flag;
            scratch_q   <= '0;
            bitcnt_q    <= '0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            state_q     <= CONV;
          end
        end
        CONV: begin
          // The shift is a 41-bit rotate. The bit leaving the top of scratch is
          // always 0 for legal values. It refills the emptied shift register,
          // whose contents no longer matter once the conversion is done.
          scratch_q <= {scratch_d[22:0], shreg_q[16]};
          shreg_q   <= {shreg_q[15:0], scratch_d[23]};
          bitcnt_q  <= bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd16)
            state_q <= LATCH;
        end
        LATCH: begin
          digits_q <= scratch_q;
          err_q    <= pend_flag_q;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Display scan: hold each digit for SCAN_DIV cycles, then advance the index.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == 3'd5) ? 3'd0 : scan_idx_q + 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Segment, anode and decimal-point decode of the registered display state.
  always_comb begin
    nib        = 4'd0;
    lead_blank = 1'b0;
    case (scan_idx_q)
      3'd0:    nib = digits_q[3:0];
      3'd1:    nib = digits_q[7:4];
      3'd2:    nib = digits_q[11:8];
      3'd3:    nib = digits_q[15:12];
      3'd4:    nib = digits_q[19:16];
      3'd5:    nib = digits_q[23:20];
      default: nib = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (scan_idx_q)
      3'd1:    lead_blank = (digits_q[23:4]  == 20'd0);
      3'd2:    lead_blank = (digits_q[23:8]  == 16'd0);
      3'd3:    lead_blank = (digits_q[23:12] == 12'd0);
      3'd4:    lead_blank = (digits_q[23:16] == 8'd0);
      3'd5:    lead_blank = (digits_q[23:20] == 4'd0);
      default: lead_blank = 1'b0;
    endcase
`endif
    if (err_q) begin
      case (scan_idx_q)
        3'd0, 3'd1: Seg = SEG_R;
        3'd2:       Seg = SEG_E;
        default:    Seg = SEG_BLANK;
      endcase
    end else if (lead_blank) begin
      Seg = SEG_BLANK;
    end else begin
      Seg = seg_of(nib);
    end
    An = ~(6'b000001 << scan_idx_q);
    Dp = 1'b1;
  end

  assign bus.Busy     = busy_q;
  assign bus.Ready    = ready_q;
  assign bus.Digits   = digits_q;
  assign bus.ErrShown = err_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display with SCAN_DIV=4.
// The driver pushes the expected {Digits, ErrShown} for each accepted Load.
// A monitor pops and compares the entry whenever Ready rises.
module tb_calc_result_display;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] An;
  logic [6:0] Seg;
  logic       Dp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] exp_q[$];

  calc_result_display_if bus();

  calc_result_display #(.SCAN_DIV(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave),
    .An    (An),
    .Seg   (Seg),
    .Dp    (Dp)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Result monitor: compare each freshly latched result with the scoreboard.
  initial begin
    logic prev_ready;
    logic [24:0] e;
    prev_ready = 1'b1;
    forever begin
      @(negedge Clk);
      if (!Reset && bus.Ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got Digits %h, expected no result", bus.Digits);
        end else begin
          e = exp_q.pop_front();
          check("digits", {8'd0, bus.Digits}, {8'd0, e[24:1]});
          check("errshown", {31'd0, bus.ErrShown}, {31'd0, e[0]});
        end
      end
      prev_ready = bus.Ready;
    end
  end

  task automatic issue(input logic [16:0] v, input logic f, input logic [23:0] exp_digits,
                       input bit push);
    if (push) exp_q.push_back({exp_digits, f});
    bus.Value = v;
    bus.Flag  = f;
    bus.Load  = 1'b1;
    tick();
    bus.Load  = 1'b0;
    bus.Value = 17'h1ABCD;
    bus.Flag  = ~f;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.Busy && n < 100) begin
      n++;
      tick();
    end
    check("ready_after_conv", {31'd0, bus.Ready}, 32'd1);
  endtask

  task automatic do_conv(input logic [16:0] v, input logic f, input logic [23:0] exp_digits);
    int n;
    issue(v, f, exp_digits, 1'b1);
    wait_ready(n);
    check("busy_cycles", n, 32'd18);
  endtask

  // Expected segments packed {d5,d4,d3,d2,d1,d0}; checked over one full scan.
  task automatic check_segs(input string name, input logic [41:0] exp);
    int idx;
    for (int c = 0; c < 24; c++) begin
      idx = -1;
      for (int i = 0; i < 6; i++) if (An[i] == 1'b0) idx = i;
      if (idx < 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_an: got An %b, expected one active digit", name, An);
      end else begin
        check(name, {25'd0, Seg}, {25'd0, exp[idx*7 +: 7]});
      end
      tick();
    end
  endtask

  initial begin
    logic [5:0] exp_an;
    int n;
    Reset     = 1'b1;
    bus.Load  = 1'b0;
    bus.Value = '0;
    bus.Flag  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_ready", {31'd0, bus.Ready}, 32'd1);
    check("rst_digits", {8'd0, bus.Digits}, 32'd0);
    check("rst_err", {31'd0, bus.ErrShown}, 32'd0);
    check("rst_an", {26'd0, An}, 32'h3E);
    check("rst_seg", {25'd0, Seg}, 32'h40);
    check("rst_dp", {31'd0, Dp}, 32'd1);
    Reset = 1'b0;

    // scan sequence, each index held four cycles
    for (int c = 0; c < 24; c++) begin
      exp_an = ~(6'b000001 << (c / 4));
      check("an_scan", {26'd0, An}, {26'd0, exp_an});
      check("dp", {31'd0, Dp}, 32'd1);
      tick();
    end
    check("an_wrap", {26'd0, An}, 32'h3E);

    do_conv(17'd12345, 1'b0, 24'h012345);
`ifdef LEADING_ZERO_BLANK_EN
    check_segs("seg_12345", {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
`else
    check_segs("seg_12345", {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
`endif

    do_conv(17'd131071, 1'b0, 24'h131071);
    do_conv(17'd0, 1'b0, 24'h000000);
`ifdef LEADING_ZERO_BLANK_EN
    check_segs("seg_zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    check_segs("seg_zero", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
`endif

    do_conv(17'd99, 1'b1, 24'h000099);
    check_segs("seg_err", {7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F});

    // Load during CONV is ignored; displayed result holds until the latch
    issue(17'd500, 1'b0, 24'h000500, 1'b1);
    repeat (5) tick();
    bus.Value = 17'd7;
    bus.Load  = 1'b1;
    tick();
    bus.Load  = 1'b0;
    check("busy_during_conv", {31'd0, bus.Busy}, 32'd1);
    check("digits_hold", {8'd0, bus.Digits}, 32'h000099);
    check("err_hold", {31'd0, bus.ErrShown}, 32'd1);
    wait_ready(n);
    repeat (20) tick();
    check("no_second_conv", {31'd0, bus.Ready}, 32'd1);

    // reset in the middle of a conversion
    issue(17'd4321, 1'b0, 24'h004321, 1'b0);
    repeat (10) tick();
    Reset = 1'b1;
    #1;
    check("midrst_digits", {8'd0, bus.Digits}, 32'd0);
    check("midrst_ready", {31'd0, bus.Ready}, 32'd1);
    check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    check("midrst_an", {26'd0, An}, 32'h3E);
    tick();
    Reset = 1'b0;
    do_conv(17'd4321, 1'b0, 24'h004321);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "time limit");
  end
endmodule
